fetch32: RTL and testbench
==========================

# fetch32

Instruction fetch stage sitting directly upstream of the instruction decoder (`idec32`). It owns the fetch program counter, drives the synchronous instruction RAM address, and presents one instruction per cycle with its address and valid flag. It redirects on taken branches using ARM-style imm24 offsets, squashing the wrong-path slot, and holds its output stable while the downstream stage stalls.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000 — first fetch address after reset.
- `NOP_INSTR`, default 32'hE1A0_0000 — instruction presented whenever `instr_valid`=0 (mov r0,r0).

**Ports**
- `clk`  in  1 — clock; all state updates on the rising edge.
- `nreset`  in  1 — asynchronous, active-low reset.
- `stall`  in  1 — downstream not accepting; hold all outputs.
- `br_taken`  in  1 — decoder resolved a taken branch for the current `instr`.
- `br_offset`  in  24 — signed word offset (imm24) of that branch.
- `imem_addr`  out  32 — instruction RAM address.
- `imem_data`  in  32 — RAM read data; valid one cycle after the address is presented.
- `instr`  out  32 — instruction to the decoder.
- `instr_pc`  out  32 — address of `instr`.
- `instr_valid`  out  1 — `instr` is a real (non-squashed) instruction.
- `pc_plus8`  out  32 — `instr_pc`+8, the architectural PC read value.
- `link_addr`  out  32 — `instr_pc`+4, the return address for BL.

## Operation

- State: `fpc` (next fetch address), `instr_pc` register, `valid` register, `hold_reg` (32 bits), `hold_valid`.
- `imem_addr` = `fpc` at all times (registered source, no combinational input path).
- `instr` = `NOP_INSTR` if !`valid`; else `hold_reg` if `hold_valid`; else `imem_data`.
- Advance (`stall`=0, no taken branch): `fpc`<=`fpc`+4; `instr_pc`<=`fpc`; `valid`<=1.
- Taken branch: accepted only when `br_taken`=1, `instr_valid`=1, and `stall`=0.
  - target = `instr_pc` + 8 + (sign_extend(`br_offset`) << 2), all mod 2^32.
  - `fpc`<=target; `valid`<=0 (the in-flight sequential fetch is squashed, giving a one-cycle bubble).
  - Next cycle `imem_addr`=target; the cycle after that, `instr_pc`=target and `valid`=1.
- `br_taken` while `instr_valid`=0 or `stall`=1 is ignored.
- Stall: `fpc`, `instr_pc`, and `valid` hold.
  - On the first stall cycle with `hold_valid`=0: `hold_reg`<=`imem_data` and `hold_valid`<=1, so the output survives the RAM re-reading `fpc`.
  - `hold_valid` clears on the first non-stall cycle; that cycle still presents `hold_reg`.
- Arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0; there is no alignment check.

## Timing

- Reset (async assert) gives `fpc`=`RESET_PC`, `instr_pc`=`RESET_PC`, `valid`=0, `hold_valid`=0, `hold_reg`=0.
  - Resulting outputs: `instr`=`NOP_INSTR`, `instr_valid`=0, `imem_addr`=`RESET_PC`, `pc_plus8`=`RESET_PC`+8, `link_addr`=`RESET_PC`+4.
- First cycle after `nreset` rises: `imem_addr`=`RESET_PC`, `instr_valid`=0.
- Second cycle after `nreset` rises: `instr_valid`=1, `instr_pc`=`RESET_PC`.
- Fetch latency is 1 cycle (address to `instr`). Steady-state throughput is 1 instruction/cycle.
- Taken-branch penalty is exactly 1 invalid cycle.
- Stall of N cycles: `instr`, `instr_pc`, and `instr_valid` are constant for N+1 cycles; the next sequential instruction appears on the cycle after `stall` falls.
- Reset mid-operation (including mid-stall or in the branch bubble) overrides everything; `hold_valid` is cleared.
- `stall` and `br_taken` together: the stall wins and the branch is not taken. The decoder must re-assert `br_taken` after the stall.

## Test plan

- Reset sequencing: `RESET_PC`=0x100, release `nreset` → cycle 1: `imem_addr`=0x100, `instr_valid`=0; cycle 2: `instr_pc`=0x100, `instr`=M[0x100], `imem_addr`=0x104.
- Straight line: M[0..0x1C] = distinct words, no stall → `instr_pc` 0,4,8,… with matching data on consecutive cycles; `link_addr`=`instr_pc`+4 and `pc_plus8`=`instr_pc`+8.
- Forward branch: `br_taken`=1, `br_offset`=3 at `instr_pc`=0x10 → next cycle `instr_valid`=0 and `instr`=`NOP_INSTR`; following cycle `instr_pc`=0x24, `instr`=M[0x24].
- Backward branch: `br_offset`=24'hFFFFFE at `instr_pc`=0x20 → target 0x20 (self-loop); the bubble repeats every other cycle while `br_taken` is held.
- Stall hold: assert `stall` for 3 cycles while `instr_pc`=0x8 → `instr`=M[0x8] for 4 cycles even though the RAM outputs M[0xC]; then `instr_pc`=0xC with no skipped or duplicated address.
- Wrap and stall+branch: `RESET_PC`=0xFFFFFFF8 → sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Separately, `br_taken` with `stall`=1 → no redirect.

Source files
------------

// File: rtl/fetch32.sv
// fetch32: instruction fetch stage feeding idec32.
// Owns the fetch PC, drives the synchronous instruction RAM address and
// presents one instruction per cycle with its address and valid flag.
// Taken branches redirect fetch with a single bubble; a downstream stall
// freezes the presented instruction, capturing the RAM word so the output
// survives the RAM re-reading the held fetch address.
//
// Flow control: stall is plain backpressure from the decoder. While stall=1
// the decoder is not consuming, so instr/instr_pc/instr_valid must not change
// on the following edge. An instruction is consumed on every rising edge with
// instr_valid=1 and stall=0. br_taken is only acted on in such a cycle.
module fetch32 #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [23:0] br_offset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [31:0] pc_plus8,
  output logic [31:0] link_addr
);

  logic [31:0] fpc;
  logic        valid;
  logic [31:0] hold_reg;
  logic        hold_valid;

  logic        br_accept;
  logic [31:0] br_disp;
  logic [31:0] br_target;

  // Branch resolution: imm24 is a signed word offset relative to PC+8.
  always_comb begin
    br_accept = br_taken & valid & ~stall;
    br_disp   = {{6{br_offset[23]}}, br_offset, 2'b00};
    br_target = instr_pc + 32'd8 + br_disp;
  end

  // Output selection: squashed slots show the NOP, stalled slots the held word.
  always_comb begin
    imem_addr   = fpc;
    instr_valid = valid;
    pc_plus8    = instr_pc + 32'd8;
    link_addr   = instr_pc + 32'd4;
    if (!valid)
      instr = NOP_INSTR;
    else if (hold_valid)
      instr = hold_reg;
    else
      instr = imem_data;
  end

  // Fetch PC, presented-PC and valid: advance, redirect, or hold under stall.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fpc      <= RESET_PC;
      instr_pc <= RESET_PC;
      valid    <= 1'b0;
    end else if (!stall) begin
      if (br_accept) begin
        // The sequential word already requested is the wrong path; drop it.
        fpc   <= br_target;
        valid <= 1'b0;
      end else begin
        fpc      <= fpc + 32'd4;
        instr_pc <= fpc;
        valid    <= 1'b1;
      end
    end
  end

  // Stall capture: grab the RAM word once, release on the first free cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hold_reg   <= 32'h0;
      hold_valid <= 1'b0;
    end else if (stall) begin
      if (!hold_valid) begin
        hold_reg   <= imem_data;
        hold_valid <= 1'b1;
      end
    end else begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch32.sv
// tb_fetch32: scoreboard bench for fetch32.
// Main instance uses RESET_PC=0; a second instance with RESET_PC=FFFFFFF8
// covers non-zero reset sequencing and 32-bit PC wrap.
module tb_fetch32;

  localparam logic [31:0] NOP     = 32'hE1A0_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic nreset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        stall;
  logic        br_taken;
  logic [23:0] br_offset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] pc_plus8;
  logic [31:0] link_addr;

  logic        w_stall;
  logic        w_br_taken;
  logic [23:0] w_br_offset;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_data;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_instr_valid;
  logic [31:0] w_pc_plus8;
  logic [31:0] w_link_addr;

  fetch32 #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) u_dut (
    .clk         (clk),
    .nreset      (nreset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .pc_plus8    (pc_plus8),
    .link_addr   (link_addr)
  );

  fetch32 #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) u_wrap (
    .clk         (clk),
    .nreset      (nreset),
    .stall       (w_stall),
    .br_taken    (w_br_taken),
    .br_offset   (w_br_offset),
    .imem_addr   (w_imem_addr),
    .imem_data   (w_imem_data),
    .instr       (w_instr),
    .instr_pc    (w_instr_pc),
    .instr_valid (w_instr_valid),
    .pc_plus8    (w_pc_plus8),
    .link_addr   (w_link_addr)
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  // Synchronous RAM: data for an address appears one edge later.
  always @(posedge clk) begin
    imem_data   <= mem_word(imem_addr);
    w_imem_data <= mem_word(w_imem_addr);
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;
  logic [64:0] exp_q[$];  // {valid, pc, instr}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_valid(input logic [31:0] pc);
    exp_q.push_back({1'b1, pc, mem_word(pc)});
  endtask

  task automatic exp_bubble();
    exp_q.push_back({1'b0, 32'h0, NOP});
  endtask

  // Compare this cycle's outputs against the scoreboard, drive the inputs
  // for this cycle, then advance to the next sampling point.
  task automatic cycle(input logic s, input logic b, input logic [23:0] off);
    logic [64:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      check("valid", {63'h0, instr_valid}, {63'h0, e[64]});
      check("instr", {32'h0, instr}, {32'h0, e[31:0]});
      if (e[64]) begin
        check("instr_pc",  {32'h0, instr_pc},  {32'h0, e[63:32]});
        check("link_addr", {32'h0, link_addr}, {32'h0, e[63:32] + 32'd4});
        check("pc_plus8",  {32'h0, pc_plus8},  {32'h0, e[63:32] + 32'd8});
      end
    end
    stall     = s;
    br_taken  = b;
    br_offset = off;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp       = 0;
    n_err       = 0;
    nreset      = 1'b0;
    stall       = 1'b0;
    br_taken    = 1'b0;
    br_offset   = 24'h0;
    w_stall     = 1'b0;
    w_br_taken  = 1'b0;
    w_br_offset = 24'h0;

    repeat (2) @(negedge clk);

    // Reset values on both instances.
    check("rst_instr",   {32'h0, instr},     {32'h0, NOP});
    check("rst_valid",   {63'h0, instr_valid}, 64'h0);
    check("rst_addr",    {32'h0, imem_addr}, 64'h0);
    check("rst_pc8",     {32'h0, pc_plus8},  64'h8);
    check("rst_link",    {32'h0, link_addr}, 64'h4);
    check("w_rst_addr",  {32'h0, w_imem_addr}, {32'h0, WRAP_PC});
    check("w_rst_pc8",   {32'h0, w_pc_plus8},  64'h0);
    check("w_rst_link",  {32'h0, w_link_addr}, {32'h0, 32'hFFFF_FFFC});

    nreset = 1'b1;

    // Cycle 1 after release: still a bubble, fetch at RESET_PC.
    check("w_c1_addr",  {32'h0, w_imem_addr}, {32'h0, WRAP_PC});
    check("w_c1_valid", {63'h0, w_instr_valid}, 64'h0);
    exp_bubble();   cycle(1'b0, 1'b0, 24'h0);

    // Cycle 2: first real instruction; wrap instance shows FFFFFFF8.
    check("c2_addr",    {32'h0, imem_addr}, 64'h4);
    check("w_c2_pc",    {32'h0, w_instr_pc}, {32'h0, WRAP_PC});
    check("w_c2_instr", {32'h0, w_instr},    {32'h0, mem_word(WRAP_PC)});
    check("w_c2_valid", {63'h0, w_instr_valid}, 64'h1);
    exp_valid(32'h0); cycle(1'b0, 1'b0, 24'h0);
    check("w_c3_pc",    {32'h0, w_instr_pc}, {32'h0, 32'hFFFF_FFFC});
    exp_valid(32'h4); cycle(1'b0, 1'b0, 24'h0);
    check("w_c4_pc",    {32'h0, w_instr_pc}, 64'h0);
    check("w_c4_instr", {32'h0, w_instr},    {32'h0, mem_word(32'h0)});

    // Stall three cycles at pc 0x8; output frozen for four cycles.
    exp_valid(32'h8); cycle(1'b1, 1'b0, 24'h0);
    check("stall_addr", {32'h0, imem_addr}, 64'hC);
    exp_valid(32'h8); cycle(1'b1, 1'b0, 24'h0);
    check("stall_ram",  {32'h0, imem_data}, {32'h0, mem_word(32'hC)});
    exp_valid(32'h8); cycle(1'b1, 1'b0, 24'h0);
    exp_valid(32'h8); cycle(1'b0, 1'b0, 24'h0);

    // Branch under stall is ignored; decoder would have to re-assert.
    exp_valid(32'hC); cycle(1'b1, 1'b1, 24'h000003);
    exp_valid(32'hC); cycle(1'b0, 1'b0, 24'h0);

    // Forward branch at 0x10, offset 3 -> 0x24.
    exp_valid(32'h10); cycle(1'b0, 1'b1, 24'h000003);
    check("fwd_bubble_addr", {32'h0, imem_addr}, 64'h24);
    exp_bubble();      cycle(1'b0, 1'b0, 24'h0);
    // Branch at 0x24, offset -3 -> 0x20.
    exp_valid(32'h24); cycle(1'b0, 1'b1, 24'hFFFFFD);
    exp_bubble();      cycle(1'b0, 1'b0, 24'h0);

    // Self-loop at 0x20 with br_taken held: bubble every other cycle.
    exp_valid(32'h20); cycle(1'b0, 1'b1, 24'hFFFFFE);
    exp_bubble();      cycle(1'b0, 1'b1, 24'hFFFFFE);
    exp_valid(32'h20); cycle(1'b0, 1'b1, 24'hFFFFFE);
    exp_bubble();      cycle(1'b0, 1'b0, 24'h0);
    exp_valid(32'h20); cycle(1'b0, 1'b0, 24'h0);
    exp_valid(32'h24); cycle(1'b0, 1'b0, 24'h0);

    // Random straight-line run with occasional stalls, no branches.
    begin
      logic [31:0] pc;
      logic        s;
      pc = 32'h28;
      for (int i = 0; i < 20; i++) begin
        s = ($urandom_range(0, 3) == 0);
        exp_valid(pc);
        cycle(s, 1'b0, 24'h0);
        if (!s) pc = pc + 32'd4;
      end
      // Reset mid-stall clears the held word.
      exp_valid(pc); cycle(1'b1, 1'b0, 24'h0);
      exp_valid(pc); cycle(1'b1, 1'b0, 24'h0);
    end
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_valid", {63'h0, instr_valid}, 64'h0);
    check("mid_rst_instr", {32'h0, instr},       {32'h0, NOP});
    check("mid_rst_addr",  {32'h0, imem_addr},   64'h0);
    @(negedge clk);
    stall  = 1'b0;
    nreset = 1'b1;
    exp_bubble();     cycle(1'b0, 1'b0, 24'h0);
    exp_valid(32'h0); cycle(1'b0, 1'b0, 24'h0);
    exp_valid(32'h4); cycle(1'b0, 1'b0, 24'h0);

    check("queue_drained", {32'h0, 32'(exp_q.size())}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
